// File: rtl/debug_uart_fifo_tx.sv
// debug_uart_fifo_tx: buffered debug UART transmitter on the tinyQV peripheral bus.
// Bytes written to TXDATA are queued in a FIFO and serialised LSB first on uart_txd
// with a runtime baud divider. STATUS reports busy/full/empty/sticky overflow/level,
// irq_tx_done flags a fully drained transmitter.
// Optional feature macro: DEBUG_UART_PARITY_EN adds CTRL parity_en/parity_odd and a
// PARITY bit after the data bits.
module debug_uart_fifo_tx #(
  parameter int CLOCK_MHZ     = 14,
  parameter int FIFO_DEPTH    = 8,
  parameter int DIVIDER_WIDTH = 13,
  parameter int PAYLOAD_BITS  = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  addr_in,
  input  logic [31:0] data_in,
  input  logic [1:0]  data_write_n,
  input  logic [1:0]  data_read_n,
  output logic [31:0] data_out,
  output logic        data_ready,
  output logic        uart_txd,
  output logic        irq_tx_done
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int BW = (PAYLOAD_BITS > 1) ? $clog2(PAYLOAD_BITS) : 1;
  localparam logic [DIVIDER_WIDTH-1:0] DIV_ONE = DIVIDER_WIDTH'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef DEBUG_UART_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  // Bus decode
  logic wr_en;
  logic push;
  assign wr_en = (data_write_n != 2'b11);
  assign push  = wr_en && (addr_in == 4'h0);

  // Reads have no side effects, so the read strobe and unused write bits are ignored
  logic unused_bits;
  assign unused_bits = ^{data_read_n, data_in};

  // FIFO storage and bookkeeping
  logic [PAYLOAD_BITS-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]           wr_ptr, rd_ptr;
  logic [PW:0]             level;
  logic                    full, empty, pop, push_ok, overflow;
  logic [PAYLOAD_BITS-1:0] head;

  assign full    = (level == (PW+1)'(FIFO_DEPTH));
  assign empty   = (level == '0);
  // A push into a full FIFO is still accepted when the head leaves in the same cycle
  assign push_ok = push && (!full || pop);
  assign head    = mem[rd_ptr];

  // Control registers
  logic [DIVIDER_WIDTH-1:0] divider, div_eff;
  logic                     irq_en;
`ifdef DEBUG_UART_PARITY_EN
  logic                     par_en, par_odd;
`endif

  assign div_eff = (divider <= DIV_ONE) ? DIV_ONE : divider;

  // Transmit state
  state_t                   state;
  logic [DIVIDER_WIDTH-1:0] cnt, div_lat;
  logic [BW-1:0]            bit_idx;
  logic [PAYLOAD_BITS-1:0]  shreg;
  logic                     bit_end;
`ifdef DEBUG_UART_PARITY_EN
  logic                     par_lat, par_bit;
`endif

  assign bit_end = (cnt == '0);
  // Head leaves the FIFO when idle, or at the end of a stop bit for gapless frames
  assign pop     = !empty && ((state == S_IDLE) || ((state == S_STOP) && bit_end));

  // FIFO data array; no reset needed, pointers define validity
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= data_in[PAYLOAD_BITS-1:0];
  end

  // FIFO pointers, level counter and sticky overflow
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop)     rd_ptr <= rd_ptr + PW'(1);
      case ({push_ok, pop})
        2'b10:   level <= level + (PW+1)'(1);
        2'b01:   level <= level - (PW+1)'(1);
        default: level <= level;
      endcase
      if (push && full && !pop)
        overflow <= 1'b1;
      else if (wr_en && (addr_in == 4'h4) && data_in[3])
        overflow <= 1'b0;
    end
  end

  // DIVIDER and CTRL register writes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      divider <= DIVIDER_WIDTH'(CLOCK_MHZ);
      irq_en  <= 1'b0;
`ifdef DEBUG_UART_PARITY_EN
      par_en  <= 1'b0;
      par_odd <= 1'b0;
`endif
    end else if (wr_en) begin
      if (addr_in == 4'h8) divider <= data_in[DIVIDER_WIDTH-1:0];
      if (addr_in == 4'hC) begin
        irq_en  <= data_in[0];
`ifdef DEBUG_UART_PARITY_EN
        par_en  <= data_in[1];
        par_odd <= data_in[2];
`endif
      end
    end
  end

  // Frame FSM: bit sequencing, divider countdown and the registered serial output
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      uart_txd <= 1'b1;
      cnt      <= '0;
      div_lat  <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
`ifdef DEBUG_UART_PARITY_EN
      par_lat  <= 1'b0;
      par_bit  <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: ;
        S_START: if (bit_end) begin
          uart_txd <= shreg[0];
          shreg    <= shreg >> 1;
          bit_idx  <= '0;
          state    <= S_DATA;
        end
        S_DATA: if (bit_end) begin
          if (bit_idx == BW'(PAYLOAD_BITS-1)) begin
            uart_txd <= 1'b1;
            state    <= S_STOP;
`ifdef DEBUG_UART_PARITY_EN
            if (par_lat) begin
              uart_txd <= par_bit;
              state    <= S_PARITY;
            end
`endif
          end else begin
            uart_txd <= shreg[0];
            shreg    <= shreg >> 1;
            bit_idx  <= bit_idx + BW'(1);
          end
        end
`ifdef DEBUG_UART_PARITY_EN
        S_PARITY: if (bit_end) begin
          uart_txd <= 1'b1;
          state    <= S_STOP;
        end
`endif
        S_STOP: if (bit_end) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase

      // Bit period countdown, reloaded from the per-frame divider at each boundary
      if (state != S_IDLE) cnt <= bit_end ? div_lat : cnt - DIV_ONE;

      // Frame launch overrides the above: latch byte, divider and parity mode
      if (pop) begin
        shreg    <= head;
        div_lat  <= div_eff - DIV_ONE;
        cnt      <= div_eff - DIV_ONE;
        uart_txd <= 1'b0;
        state    <= S_START;
`ifdef DEBUG_UART_PARITY_EN
        par_lat  <= par_en;
        par_bit  <= (^head) ^ par_odd;
`endif
      end
    end
  end

  // Register read mux and outputs
  logic [31:0] status_w, ctrl_w;
  logic        busy;
  assign busy     = (state != S_IDLE);
  assign status_w = {16'h0, 8'(level), 4'h0, overflow, empty, full, busy};
`ifdef DEBUG_UART_PARITY_EN
  assign ctrl_w   = {29'h0, par_odd, par_en, irq_en};
`else
  assign ctrl_w   = {31'h0, irq_en};
`endif

  always_comb begin
    data_out = 32'h0;
    case (addr_in)
      4'h4:    data_out = status_w;
      4'h8:    data_out = 32'(divider);
      4'hC:    data_out = ctrl_w;
      default: data_out = 32'h0;
    endcase
  end

  assign data_ready  = 1'b1;
  assign irq_tx_done = irq_en && empty && !busy;

endmodule

// File: tb/tb_debug_uart_fifo_tx.sv
// Bench for debug_uart_fifo_tx: builds the expected uart_txd waveform per cycle from
// the frame rules (start, LSB-first data, optional parity, stop, divider clocks each)
// and compares it with the captured line, plus register and interrupt checks.
module tb_debug_uart_fifo_tx;
  localparam int DEPTH = 8;
  localparam int PB    = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  addr_in = 4'h0;
  logic [31:0] data_in = 32'h0;
  logic [1:0]  data_write_n = 2'b11;
  logic [1:0]  data_read_n  = 2'b11;
  logic [31:0] data_out;
  logic        data_ready, uart_txd, irq_tx_done;

  int n_tests = 0;
  int n_fail  = 0;

  logic cap_on = 1'b0;
  logic cap_q[$];
  logic exp_q[$];

  debug_uart_fifo_tx #(.CLOCK_MHZ(14), .FIFO_DEPTH(DEPTH), .DIVIDER_WIDTH(13), .PAYLOAD_BITS(PB)) dut (
    .clk(clk), .rst(rst), .addr_in(addr_in), .data_in(data_in),
    .data_write_n(data_write_n), .data_read_n(data_read_n), .data_out(data_out),
    .data_ready(data_ready), .uart_txd(uart_txd), .irq_tx_done(irq_tx_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (cap_on) cap_q.push_back(uart_txd);

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time exceeded, required completion");
    $fatal(1, "watchdog");
  end

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    addr_in = a; data_in = d; data_write_n = 2'b00;
    @(posedge clk); #1;
    data_write_n = 2'b11;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] v);
    addr_in = a; data_read_n = 2'b00;
    #1 v = data_out;
    data_read_n = 2'b11;
  endtask

  // Expected line for one frame
  task automatic add_frame(input logic [7:0] b, input int div, input bit par_on, input bit odd);
    int   eff;
    logic bits[$];
    eff = (div <= 1) ? 1 : div;
    bits.push_back(1'b0);
    for (int i = 0; i < PB; i++) bits.push_back(b[i]);
    if (par_on) bits.push_back((^b) ^ odd);
    bits.push_back(1'b1);
    foreach (bits[i]) repeat (eff) exp_q.push_back(bits[i]);
  endtask

  task automatic add_idle(input int n);
    repeat (n) exp_q.push_back(1'b1);
  endtask

  task automatic start_cap();
    cap_q.delete();
    cap_on = 1'b1;
  endtask

  // Waits (bounded) for the capture to cover the expectation; bad=-1 if it never did
  task automatic wait_cap(output int bad, output int first);
    bad = 0; first = -1;
    for (int i = 0; i < 20000 && cap_q.size() < exp_q.size(); i++) @(posedge clk);
    @(posedge clk); #1;
    cap_on = 1'b0;
    if (cap_q.size() < exp_q.size()) bad = -1;
    else foreach (exp_q[i]) if (cap_q[i] !== exp_q[i]) begin
      bad++;
      if (first < 0) first = i;
    end
    exp_q.delete();
  endtask

  task automatic test_reset();
    logic [31:0] v;
    repeat (3) @(posedge clk); #1;
    n_tests++; if (uart_txd !== 1'b1) begin n_fail++; $display("FAIL reset_txd_held: got %b required 1", uart_txd); end
    @(negedge clk) rst = 1'b0;
    #1;
    bus_read(4'h4, v);
    n_tests++; if (v !== 32'h4) begin n_fail++; $display("FAIL reset_status: got %h required 00000004", v); end
    bus_read(4'h8, v);
    n_tests++; if (v !== 32'd14) begin n_fail++; $display("FAIL reset_divider: got %0d required 14", v); end
    bus_read(4'hC, v);
    n_tests++; if (v !== 32'h0) begin n_fail++; $display("FAIL reset_ctrl: got %h required 0", v); end
    bus_read(4'h0, v);
    n_tests++; if (v !== 32'h0) begin n_fail++; $display("FAIL reset_txdata_read: got %h required 0", v); end
    n_tests++; if (irq_tx_done !== 1'b0 || uart_txd !== 1'b1 || data_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_outputs: irq=%b txd=%b ready=%b required 0 1 1", irq_tx_done, uart_txd, data_ready);
    end
  endtask

  task automatic test_single_frame();
    logic [31:0] v;
    int bad, first;
    bus_write(4'hC, 32'h1);
    n_tests++; if (irq_tx_done !== 1'b1) begin n_fail++; $display("FAIL irq_idle_enabled: got %b required 1", irq_tx_done); end
    add_idle(1); add_frame(8'h55, 14, 0, 0); add_idle(2);
    bus_write(4'h0, 32'h55);
    start_cap();
    bus_read(4'h4, v);
    n_tests++; if (v !== 32'h100) begin n_fail++; $display("FAIL status_after_push: got %h required 00000100", v); end
    n_tests++; if (irq_tx_done !== 1'b0) begin n_fail++; $display("FAIL irq_pending_data: got %b required 0", irq_tx_done); end
    @(posedge clk); #1;
    bus_read(4'h4, v);
    n_tests++; if (v !== 32'h5) begin n_fail++; $display("FAIL status_after_pop: got %h required 00000005", v); end
    n_tests++; if (uart_txd !== 1'b0) begin n_fail++; $display("FAIL start_bit_latency: got %b required 0", uart_txd); end
    wait_cap(bad, first);
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL frame_55: %0d cycles differ (first %0d), required 0", bad, first); end
    n_tests++; if (irq_tx_done !== 1'b1) begin n_fail++; $display("FAIL irq_after_stop: got %b required 1", irq_tx_done); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] v, d[DEPTH+2];
    logic [31:0] exp_st;
    int div, bad, first;
    div = $urandom_range(2, 4);
    bus_write(4'h8, 32'(div));
    foreach (d[i]) d[i] = $urandom;
    add_idle(1);
    for (int i = 0; i <= DEPTH; i++) add_frame(d[i][7:0], div, 0, 0);
    add_idle(2);
    bus_write(4'h0, d[0]);
    start_cap();
    for (int i = 1; i < DEPTH + 2; i++) bus_write(4'h0, d[i]);
    bus_read(4'h4, v);
    exp_st = (32'(DEPTH) << 8) | 32'hB;
    n_tests++; if (v !== exp_st) begin n_fail++; $display("FAIL overflow_status: got %h required %h", v, exp_st); end
    wait_cap(bad, first);
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL back_to_back_frames: %0d cycles differ (first %0d), required 0", bad, first); end
    bus_read(4'h4, v);
    n_tests++; if (v !== 32'hC) begin n_fail++; $display("FAIL overflow_sticky: got %h required 0000000c", v); end
    bus_write(4'h4, 32'h8);
    bus_read(4'h4, v);
    n_tests++; if (v !== 32'h4) begin n_fail++; $display("FAIL overflow_clear: got %h required 00000004", v); end
  endtask

  task automatic test_divider_change();
    logic [31:0] v;
    logic [7:0] a, b, c;
    int bad, first;
    a = 8'($urandom); b = 8'($urandom); c = 8'($urandom);
    bus_write(4'h8, 32'd14);
    add_idle(1); add_frame(a, 14, 0, 0); add_frame(b, 4, 0, 0); add_idle(2);
    bus_write(4'h0, {24'h0, a});
    start_cap();
    repeat (30) @(posedge clk);
    bus_write(4'h8, 32'd4);
    bus_read(4'h8, v);
    n_tests++; if (v !== 32'd4) begin n_fail++; $display("FAIL divider_readback: got %0d required 4", v); end
    bus_write(4'h0, {24'h0, b});
    wait_cap(bad, first);
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL divider_change: %0d cycles differ (first %0d), required 0", bad, first); end
    bus_write(4'h8, 32'd0);
    add_idle(1); add_frame(c, 0, 0, 0); add_idle(2);
    bus_write(4'h0, {24'h0, c});
    start_cap();
    wait_cap(bad, first);
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL divider_zero: %0d cycles differ (first %0d), required 0", bad, first); end
  endtask

  task automatic test_parity();
    logic [31:0] v;
`ifdef DEBUG_UART_PARITY_EN
    int bad, first;
    bus_write(4'h8, 32'd3);
    bus_write(4'hC, 32'h3);
    add_idle(1); add_frame(8'h07, 3, 1, 0); add_idle(2);
    bus_write(4'h0, 32'h07);
    start_cap();
    wait_cap(bad, first);
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL parity_even: %0d cycles differ (first %0d), required 0", bad, first); end
    bus_write(4'hC, 32'h7);
    bus_read(4'hC, v);
    n_tests++; if (v !== 32'h7) begin n_fail++; $display("FAIL ctrl_parity_readback: got %h required 7", v); end
    add_idle(1); add_frame(8'h07, 3, 1, 1); add_idle(2);
    bus_write(4'h0, 32'h07);
    start_cap();
    wait_cap(bad, first);
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL parity_odd: %0d cycles differ (first %0d), required 0", bad, first); end
`else
    bus_write(4'hC, 32'h7);
    bus_read(4'hC, v);
    n_tests++; if (v !== 32'h1) begin n_fail++; $display("FAIL ctrl_no_parity: got %h required 1", v); end
`endif
    bus_write(4'hC, 32'h1);
  endtask

  task automatic test_random();
    logic [31:0] v, d;
    int div, n, bad, first;
    for (int it = 0; it < 4; it++) begin
      div = $urandom_range(0, 6);
      n   = $urandom_range(1, DEPTH);
      bus_write(4'h8, 32'(div));
      add_idle(1);
      for (int k = 0; k < n; k++) begin
        d = $urandom;
        add_frame(d[7:0], div, 0, 0);
        bus_write(4'h0, d);
        if (k == 0) start_cap();
      end
      add_idle(2);
      wait_cap(bad, first);
      n_tests++; if (bad != 0) begin n_fail++; $display("FAIL random_%0d div=%0d n=%0d: %0d cycles differ (first %0d), required 0", it, div, n, bad, first); end
      bus_read(4'h4, v);
      n_tests++; if (v !== 32'h4 || irq_tx_done !== 1'b1) begin n_fail++; $display("FAIL random_%0d_drained: status %h irq %b required 00000004 1", it, v, irq_tx_done); end
    end
  endtask

  task automatic test_reset_midframe();
    logic [31:0] v;
    bus_write(4'h8, 32'd14);
    bus_write(4'h0, 32'h00);
    bus_write(4'h0, 32'hA5);
    repeat (30) @(posedge clk); #1;
    n_tests++; if (uart_txd !== 1'b0) begin n_fail++; $display("FAIL midframe_data_bit: got %b required 0", uart_txd); end
    #2 rst = 1'b1;
    #1;
    n_tests++; if (uart_txd !== 1'b1) begin n_fail++; $display("FAIL async_reset_txd: got %b required 1", uart_txd); end
    @(negedge clk) rst = 1'b0;
    #1;
    bus_read(4'h4, v);
    n_tests++; if (v !== 32'h4) begin n_fail++; $display("FAIL reset_discard_status: got %h required 00000004", v); end
    bus_read(4'h8, v);
    n_tests++; if (v !== 32'd14 || irq_tx_done !== 1'b0) begin n_fail++; $display("FAIL reset_regs: div %0d irq %b required 14 0", v, irq_tx_done); end
    repeat (40) @(posedge clk); #1;
    n_tests++; if (uart_txd !== 1'b1) begin n_fail++; $display("FAIL reset_no_resume: got %b required 1", uart_txd); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_divider_change();
    test_parity();
    test_random();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/debug_uart_fifo_tx.md
# debug_uart_fifo_tx

Buffered, parametrised debug UART transmitter for the tinyQV SoC top, replacing the unbuffered debug UART TX in the debug peripheral slot. Firmware pushes bytes into a FIFO through the standard peripheral register interface and keeps executing; the block serialises them onto `uart_txd` using a runtime-programmable baud divider. It also reports FIFO level and overflow, and raises a maskable interrupt when transmission has fully drained.

## Interface
Parameters:
- `CLOCK_MHZ`, 14: system clock in MHz; the reset divider value is `CLOCK_MHZ`, giving 1 Mbaud.
- `FIFO_DEPTH`, 8: FIFO entries; must be a power of two, ≥2.
- `DIVIDER_WIDTH`, 13: width of the baud divider register.
- `PAYLOAD_BITS`, 8: data bits per frame, 5..8.

Ports:
- `clk` in 1: system clock; the only clock.
- `rst` in 1: asynchronous, active-high reset.
- `addr_in` in 4: register byte offset; only 0x0, 0x4, 0x8 and 0xC decode.
- `data_in` in 32: write data.
- `data_write_n` in 2: 2'b11 means idle; any other value is a write this cycle.
- `data_read_n` in 2: 2'b11 means idle; any other value is a read this cycle.
- `data_out` out 32: read data, combinational from `addr_in`.
- `data_ready` out 1: tied to 1; every access completes in one cycle.
- `uart_txd` out 1: serial output, idle high.
- `irq_tx_done` out 1: level interrupt.

## Operation
Registers:
- 0x0 TXDATA, write-only: a write pushes `data_in[PAYLOAD_BITS-1:0]`. Reads return 0.
- 0x4 STATUS:
  - bit0 `busy`: FSM not in IDLE.
  - bit1 `full`.
  - bit2 `empty`.
  - bit3 `overflow`: sticky; writing 1 to bit3 clears it.
  - bits[15:8] FIFO level.
- 0x8 DIVIDER, RW: bit period in clocks. Values 0 and 1 are treated as 1.
- 0xC CTRL, RW: bit0 `irq_en`. Bits 1 and 2 are described under Configuration.

Output equations:
- `irq_tx_done` = `irq_en` & `empty` & FSM in IDLE.

FSM states: IDLE → START → DATA → (PARITY) → STOP → IDLE/START.
- IDLE: if the FIFO is non-empty, pop the head, latch it into the shift register, latch DIVIDER and the CTRL parity bits, and go to START.
- START: drive `uart_txd` low for one bit period.
- DATA: send `PAYLOAD_BITS` bits, LSB first, one bit period each.
- PARITY: present only when compiled in and enabled (see Configuration).
- STOP: drive high for one bit period. At its end, if the FIFO is non-empty, pop and go directly to START (back-to-back frames with no idle gap); otherwise go to IDLE.

Bit timing:
- A down-counter reloads with the latched divider at each bit boundary.
- A new DIVIDER value never affects a frame already in progress.

FIFO boundary rules:
- Push while full with no pop in the same cycle: byte dropped, `overflow` set, level unchanged.
- Push and pop in the same cycle: both take effect and the level is unchanged, including when full.
- Pointers are `log2(FIFO_DEPTH)` bits and wrap naturally. The level counter is `log2(FIFO_DEPTH)+1` bits.

Reset values:
- `uart_txd`=1, FSM=IDLE, FIFO empty (level 0), `overflow`=0.
- DIVIDER=`CLOCK_MHZ`, CTRL=0, `irq_tx_done`=0, `data_out` reflects the reset register values.
- Reset asserted mid-frame forces `uart_txd` high immediately (asynchronously) and discards all queued data.

## Timing
- TXDATA write sampled at edge N (FIFO empty, FSM idle):
  - level=1 after edge N.
  - Pop happens at edge N+1; `uart_txd` is low after edge N+1 and `busy`=1.
- Frame length:
  - (1 + `PAYLOAD_BITS` + 1) × divider clocks.
  - Add one divider period when parity is active.
- `uart_txd` is driven directly from a flop; no combinational path from the bus.
- STATUS and level reads reflect state after the previous edge.
- A write and a read in the same cycle are not issued by the CPU; behaviour is undefined.

## Configuration
- `DEBUG_UART_PARITY_EN` defined:
  - CTRL bit1 `parity_en` and bit2 `parity_odd` are implemented.
  - When `parity_en` is latched at frame start, a PARITY bit follows the data bits: XOR of the data bits, inverted if `parity_odd`.
- Not defined:
  - CTRL bits 1 and 2 read 0 and writes to them are ignored.
  - No PARITY state and no parity logic is synthesised.

## Test plan
- After reset: `uart_txd`=1, STATUS=0x00000004, DIVIDER=14, `irq_tx_done`=0.
- Write CTRL=1, then TXDATA=0x55, divider 14 → `uart_txd` shows 0,1,0,1,0,1,0,1,0,1, 14 clocks per bit, starting one cycle after the write. `irq_tx_done` rises after the stop bit.
- Write FIFO_DEPTH+2 bytes back-to-back while the first frame is running → one byte enters the shifter and FIFO_DEPTH are stored. The last byte is dropped and sets `overflow` (STATUS bit3=1). Stored frames are emitted with no idle gap between stop and start. Writing STATUS=0x8 clears bit3.
- DIVIDER changed from 14 to 4 mid-frame → the current frame keeps 14-clock bits and the next frame uses 4-clock bits. DIVIDER=0 gives 1-clock bits.
- Assert `rst` during the DATA phase of 0x00 → `uart_txd` returns to 1 without waiting for a clock edge, and level is 0 after release.
- With `DEBUG_UART_PARITY_EN` defined: CTRL=0x3, TX 0x07 → parity bit = 1; CTRL=0x7 → parity bit = 0. Without the macro, CTRL reads back 0x1 after writing 0x7.
